pipeline_stall_controller: RTL and testbench

PIPELINE_STALL_CONTROLLER -- requirements
Module: pipeline_stall_controller

---
 rtl/pipeline_stall_controller_pkg.sv | 27 ++
 rtl/pipeline_stall_controller_if.sv | 32 +++
 rtl/pipeline_stall_controller_hazard_detect.sv | 31 +++
 rtl/pipeline_stall_controller.sv | 111 +++++++++++
 tb/tb_pipeline_stall_controller.sv | 164 ++++++++++++++++
 5 files changed

// File: rtl/pipeline_stall_controller_pkg.sv
// Shared pipeline constants: FSM encoding, register-zero number, timeout default
// and the packed bundle of pipeline-register control outputs.
package pipeline_stall_controller_pkg;

    localparam logic [0:0] ST_RUN      = 1'b0;
    localparam logic [0:0] ST_MEM_WAIT = 1'b1;

    localparam logic [4:0] REG_ZERO            = 5'd0;
    localparam int         MEM_TIMEOUT_DEFAULT = 16;
    localparam int         WAIT_W              = 8;

    typedef struct packed {
        logic pc_we;
        logic ifid_we;
        logic idex_we;
        logic exmem_we;
        logic ifid_flush;
        logic idex_bubble;
        logic memwb_bubble;
    } ctrl_t;

    localparam ctrl_t CTRL_NORMAL   = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    localparam ctrl_t CTRL_MEM_HOLD = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    localparam ctrl_t CTRL_BRANCH   = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    localparam ctrl_t CTRL_LOAD_USE = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};

endpackage

// File: rtl/pipeline_stall_controller_if.sv
// Hazard inputs from the ID/EX/MEM stages and the pipeline-register controls
// returned to them; master is the pipeline side, slave the stall controller.
interface pipeline_stall_controller_if;
    logic [4:0] IDRs;
    logic [4:0] IDRt;
    logic       IDUsesRt;
    logic       EXMemRead;
    logic [4:0] EXDest;
    logic       BranchTaken;
    logic       MemReq;
    logic       MemReady;

    logic       PCWriteEnable;
    logic       IFIDWriteEnable;
    logic       IDEXWriteEnable;
    logic       EXMEMWriteEnable;
    logic       IFIDFlush;
    logic       IDEXBubble;
    logic       MEMWBBubble;

    modport master (
        output IDRs, IDRt, IDUsesRt, EXMemRead, EXDest, BranchTaken, MemReq, MemReady,
        input  PCWriteEnable, IFIDWriteEnable, IDEXWriteEnable, EXMEMWriteEnable,
        input  IFIDFlush, IDEXBubble, MEMWBBubble
    );

    modport slave (
        input  IDRs, IDRt, IDUsesRt, EXMemRead, EXDest, BranchTaken, MemReq, MemReady,
        output PCWriteEnable, IFIDWriteEnable, IDEXWriteEnable, EXMEMWriteEnable,
        output IFIDFlush, IDEXBubble, MEMWBBubble
    );
endinterface

// File: rtl/pipeline_stall_controller_hazard_detect.sv
// Combinational load-use detector: a load in EX whose destination feeds the
// instruction in ID. Writes to register zero never create a dependency.
module hazard_detect
    import pipeline_stall_controller_pkg::*;
(
    input  logic [4:0] IDRs,
    input  logic [4:0] IDRt,
    input  logic       IDUsesRt,
    input  logic       EXMemRead,
    input  logic [4:0] EXDest,
    output logic       LoadUse
);

    logic [4:0] rs_bit_eq;
    logic [4:0] rt_bit_eq;

    generate
        for (genvar gi = 0; gi < 5; gi++) begin : g_cmp
            assign rs_bit_eq[gi] = ~(EXDest[gi] ^ IDRs[gi]);
            assign rt_bit_eq[gi] = ~(EXDest[gi] ^ IDRt[gi]);
        end
    endgenerate

    logic rs_match;
    logic rt_match;

    assign rs_match = &rs_bit_eq;
    assign rt_match = IDUsesRt & (&rt_bit_eq);
    assign LoadUse  = EXMemRead & (EXDest != REG_ZERO) & (rs_match | rt_match);

endmodule

// File: rtl/pipeline_stall_controller.sv
// Pipeline stall/flush controller: memory hold > taken branch > load-use,
// with a bounded data-memory wait that is abandoned via a sticky MemTimeout.
module pipeline_stall_controller
    import pipeline_stall_controller_pkg::*;
#(
    parameter int MEM_TIMEOUT = MEM_TIMEOUT_DEFAULT
) (
    input  logic                          clk,
    input  logic                          Reset,
    pipeline_stall_controller_if.slave    bus,
    output logic                          MemTimeout,
    output logic [31:0]                   StallCycles,
    output logic [15:0]                   FlushCount
);

    logic              load_use;
    logic              mem_ready_eff;
    logic              mem_hold;
    ctrl_t             ctrl;

    logic [0:0]        state_reg;
    logic [0:0]        state_next;
    logic [WAIT_W-1:0] wait_count_reg;
    logic [WAIT_W-1:0] wait_count_next;
    logic              mem_timeout_reg;
    logic              mem_timeout_next;
    logic [31:0]       stall_cycles_reg;
    logic [15:0]       flush_count_reg;

    hazard_detect u_hazard_detect (
        .IDRs      (bus.IDRs),
        .IDRt      (bus.IDRt),
        .IDUsesRt  (bus.IDUsesRt),
        .EXMemRead (bus.EXMemRead),
        .EXDest    (bus.EXDest),
        .LoadUse   (load_use)
    );

    // Once the wait has been abandoned, the memory is treated as always ready.
    assign mem_ready_eff = bus.MemReady | mem_timeout_reg;
    assign mem_hold      = bus.MemReq & ~mem_ready_eff;

    always_comb begin
        ctrl = CTRL_NORMAL;
        if (!Reset) begin
            if (mem_hold)
                ctrl = CTRL_MEM_HOLD;
            else if (bus.BranchTaken)
                ctrl = CTRL_BRANCH;
            else if (load_use)
                ctrl = CTRL_LOAD_USE;
        end
    end

    assign bus.PCWriteEnable    = ctrl.pc_we;
    assign bus.IFIDWriteEnable  = ctrl.ifid_we;
    assign bus.IDEXWriteEnable  = ctrl.idex_we;
    assign bus.EXMEMWriteEnable = ctrl.exmem_we;
    assign bus.IFIDFlush        = ctrl.ifid_flush;
    assign bus.IDEXBubble       = ctrl.idex_bubble;
    assign bus.MEMWBBubble      = ctrl.memwb_bubble;

    always_comb begin
        state_next       = state_reg;
        wait_count_next  = wait_count_reg;
        mem_timeout_next = mem_timeout_reg;
        case (state_reg)
            ST_RUN: begin
                if (mem_hold) begin
                    state_next      = ST_MEM_WAIT;
                    wait_count_next = 8'd1;
                end
            end
            default: begin
                if (!mem_hold) begin
                    state_next      = ST_RUN;
                    wait_count_next = '0;
                end else if (wait_count_reg == WAIT_W'(MEM_TIMEOUT)) begin
                    state_next       = ST_RUN;
                    wait_count_next  = '0;
                    mem_timeout_next = 1'b1;
                end else begin
                    wait_count_next = wait_count_reg + 8'd1;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (Reset) begin
            state_reg        <= ST_RUN;
            wait_count_reg   <= '0;
            mem_timeout_reg  <= 1'b0;
            stall_cycles_reg <= '0;
            flush_count_reg  <= '0;
        end else begin
            state_reg       <= state_next;
            wait_count_reg  <= wait_count_next;
            mem_timeout_reg <= mem_timeout_next;
            if (!ctrl.pc_we)
                stall_cycles_reg <= stall_cycles_reg + 32'd1;
            if (ctrl.ifid_flush)
                flush_count_reg <= flush_count_reg + 16'd1;
        end
    end

    assign MemTimeout  = mem_timeout_reg;
    assign StallCycles = stall_cycles_reg;
    assign FlushCount  = flush_count_reg;

endmodule

// File: tb/tb_pipeline_stall_controller.sv
// Directed bench for pipeline_stall_controller with hand-computed expectations
// (MEM_TIMEOUT = 4 so the abandon path is reachable quickly).
module tb_pipeline_stall_controller;

    logic        clk;
    logic        Reset;
    logic        MemTimeout;
    logic [31:0] StallCycles;
    logic [15:0] FlushCount;

    int tests_run = 0;
    int tests_failed = 0;

    // {PC, IFID, IDEX, EXMEM write enables, IFIDFlush, IDEXBubble, MEMWBBubble}
    localparam logic [6:0] EXP_NORMAL = 7'b1111_000;
    localparam logic [6:0] EXP_HOLD   = 7'b0000_001;
    localparam logic [6:0] EXP_BRANCH = 7'b1111_110;
    localparam logic [6:0] EXP_LOADU  = 7'b0011_010;

    pipeline_stall_controller_if bus ();

    pipeline_stall_controller #(.MEM_TIMEOUT(4)) dut (
        .clk         (clk),
        .Reset       (Reset),
        .bus         (bus),
        .MemTimeout  (MemTimeout),
        .StallCycles (StallCycles),
        .FlushCount  (FlushCount)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [6:0] ctrl_vec();
        return {bus.PCWriteEnable, bus.IFIDWriteEnable, bus.IDEXWriteEnable,
                bus.EXMEMWriteEnable, bus.IFIDFlush, bus.IDEXBubble, bus.MEMWBBubble};
    endfunction

    task automatic drive(input logic mr, input logic [4:0] dst, input logic [4:0] rs,
                         input logic [4:0] rt, input logic urt, input logic br,
                         input logic req, input logic rdy);
        bus.EXMemRead   = mr;
        bus.EXDest      = dst;
        bus.IDRs        = rs;
        bus.IDRt        = rt;
        bus.IDUsesRt    = urt;
        bus.BranchTaken = br;
        bus.MemReq      = req;
        bus.MemReady    = rdy;
        #1;
    endtask

    // Apply inputs, check the combinational controls, clock once, then settle.
    task automatic step(input string tag, input logic [6:0] exp_ctrl);
        check_value(tag, {25'd0, ctrl_vec()}, {25'd0, exp_ctrl});
        $display("[TB] %s ctrl=%b stall=%0d flush=%0d", tag, ctrl_vec(), StallCycles, FlushCount);
        @(posedge clk);
        #1;
    endtask

    initial begin
        Reset = 1'b1;
        @(posedge clk);
        #1;
        // Reset dominates: pending memory wait and branch must not show up.
        drive(1'b1, 5'd5, 5'd5, 5'd0, 1'b0, 1'b1, 1'b1, 1'b0);
        step("reset_ctrl", EXP_NORMAL);
        check_value("reset_state", {31'd0, dut.state_reg}, 32'd0);
        check_value("reset_stall", StallCycles, 32'd0);
        check_value("reset_flush", {16'd0, FlushCount}, 32'd0);
        check_value("reset_timeout", {31'd0, MemTimeout}, 32'd0);
        Reset = 1'b0;

        drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        step("idle", EXP_NORMAL);
        check_value("idle_stall", StallCycles, 32'd0);

        drive(1'b1, 5'd5, 5'd5, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        step("load_use_rs", EXP_LOADU);
        check_value("load_use_stall", StallCycles, 32'd1);
        drive(1'b0, 5'd5, 5'd5, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        step("after_load_use", EXP_NORMAL);

        drive(1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        step("zero_dest", EXP_NORMAL);
        drive(1'b1, 5'd7, 5'd3, 5'd7, 1'b0, 1'b0, 1'b0, 1'b0);
        step("rt_unused", EXP_NORMAL);
        check_value("no_stall_stall", StallCycles, 32'd1);
        drive(1'b1, 5'd7, 5'd3, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0);
        step("rt_used", EXP_LOADU);
        check_value("rt_stall", StallCycles, 32'd2);

        drive(1'b1, 5'd5, 5'd5, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0);
        step("branch_over_load_use", EXP_BRANCH);
        check_value("branch_flush", {16'd0, FlushCount}, 32'd1);
        check_value("branch_stall", StallCycles, 32'd2);

        // Three-cycle memory wait with branch and load-use also asserted.
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 5'd5, 5'd5, 5'd0, 1'b0, 1'b1, 1'b1, 1'b0);
            step($sformatf("mem_wait_%0d", i), EXP_HOLD);
            check_value($sformatf("mem_wait_state_%0d", i), {31'd0, dut.state_reg}, 32'd1);
        end
        check_value("mem_wait_stall", StallCycles, 32'd5);
        check_value("mem_wait_flush", {16'd0, FlushCount}, 32'd1);
        drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1);
        step("mem_ready", EXP_NORMAL);
        check_value("mem_ready_state", {31'd0, dut.state_reg}, 32'd0);
        check_value("mem_ready_wait", {24'd0, dut.wait_count_reg}, 32'd0);

        // Timeout: one RUN cycle plus four MEM_WAIT cycles, then abandoned.
        for (int i = 0; i < 5; i++) begin
            drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
            check_value($sformatf("pre_timeout_%0d", i), {31'd0, MemTimeout}, 32'd0);
            step($sformatf("timeout_hold_%0d", i), EXP_HOLD);
        end
        check_value("timeout_flag", {31'd0, MemTimeout}, 32'd1);
        check_value("timeout_state", {31'd0, dut.state_reg}, 32'd0);
        check_value("timeout_stall", StallCycles, 32'd10);
        drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
        step("released_after_timeout", EXP_NORMAL);
        check_value("released_stall", StallCycles, 32'd10);
        check_value("timeout_sticky", {31'd0, MemTimeout}, 32'd1);

        // Reset mid-wait: build up nonzero counters and an in-flight wait first.
        Reset = 1'b1;
        drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        step("reset_again", EXP_NORMAL);
        Reset = 1'b0;
        drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0);
        step("branch_pre_reset", EXP_BRANCH);
        drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
        step("hold_pre_reset_0", EXP_HOLD);
        step("hold_pre_reset_1", EXP_HOLD);
        check_value("pre_reset_wait", {24'd0, dut.wait_count_reg}, 32'd2);
        check_value("pre_reset_stall", StallCycles, 32'd2);
        Reset = 1'b1;
        #1;
        step("reset_mid_wait", EXP_NORMAL);
        check_value("mid_reset_state", {31'd0, dut.state_reg}, 32'd0);
        check_value("mid_reset_wait", {24'd0, dut.wait_count_reg}, 32'd0);
        check_value("mid_reset_timeout", {31'd0, MemTimeout}, 32'd0);
        check_value("mid_reset_stall", StallCycles, 32'd0);
        check_value("mid_reset_flush", {16'd0, FlushCount}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
